// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor, Diff = A - B - Bin, computed
//               LSB first with one full-subtractor cell and a borrow flop.
//               Uses a start/busy/done handshake.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               start  - request, sampled only when idle
//               A, B   - minuend / subtrahend, sampled on the accepting edge
//               Bin    - borrow-in, sampled on the accepting edge
//               busy   - high while shifting or presenting the result
//               done   - one-cycle pulse, Diff/Bout valid
//               Diff   - registered result, held until the next result
//               Bout   - registered final borrow-out, held with Diff
//               ovf    - signed overflow (only with SERIAL_SUB_OVF_EN)
// Options     : define SERIAL_SUB_OVF_EN to add the ovf output
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic               d_bit;
    logic               br_next;

    // Full-subtractor cell on the current LSBs
    assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                res_d = {d_bit, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    // On the last bit the shift registers hold the operand
                    // sign bits in position 0, and d_bit is the result sign.
                    ovf_d   = (a_q[0] != b_q[0]) & (d_bit != a_q[0]);
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    assign ovf = ovf_q;
`else
    // Overflow flop is trimmed away when the output is not built
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH = 4).
//               Directed vector table, hand-written handshake/reset
//               sequences and randomized operands against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf_w;

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .Bin   (bin_in),
        .busy  (busy),
        .done  (done),
        .Diff  (diff),
        .Bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf_w)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] exp_diff;
        logic       exp_bout;
        logic       exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    task automatic model(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         output logic [3:0] d, output logic bo, output logic ov);
        int full;
        full = int'(a) - int'(b) - int'(bin);
        d    = 4'(full);
        bo   = (full < 0);
        ov   = (a[3] != b[3]) && (d[3] != a[3]);
    endtask

    // Issue one operation from a negedge; returns result and cycles to done.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          output logic [3:0] d, output logic bo, output logic ov,
                          output int lat);
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        bin_in = bin;
        @(negedge clk);
        start  = 1'b0;
        a_in   = ~a;
        b_in   = ~b;
        bin_in = ~bin;
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < WIDTH + 4) begin
            @(negedge clk);
            lat++;
        end
        d  = diff;
        bo = bout;
        ov = ovf_w;
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [3:0] got_d, exp_d;
        logic       got_bo, exp_bo, got_ov, exp_ov;
        int         lat;
        int         seen;

        vecs[0] = '{4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0};
        vecs[1] = '{4'b0011, 4'b0111, 1'b0, 4'b1100, 1'b1, 1'b0};
        vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0};
        vecs[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
        vecs[4] = '{4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1};
        vecs[5] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};

        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        bin_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: no activity for 5 cycles
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("idle_no_activity", 32'(seen), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_bout", 32'(bout), 32'd0);
        chk("reset_ovf", 32'(ovf_w), 32'd0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, got_d, got_bo, got_ov, lat);
            chk("vec_latency", 32'(lat), 32'(WIDTH));
            chk("vec_diff", 32'(got_d), 32'(vecs[i].exp_diff));
            chk("vec_bout", 32'(got_bo), 32'(vecs[i].exp_bout));
`ifdef SERIAL_SUB_OVF_EN
            chk("vec_ovf", 32'(got_ov), 32'(vecs[i].exp_ovf));
`endif
        end

        // start held high while busy: ignored until IDLE is re-entered
        start  = 1'b1;
        a_in   = 4'b0001;
        b_in   = 4'b0001;
        bin_in = 1'b0;
        @(negedge clk);
        a_in = 4'b1111;
        b_in = 4'b0000;
        lat  = 0;
        while (!done && lat < WIDTH + 4) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_start_latency", 32'(lat), 32'(WIDTH));
        chk("busy_start_first_diff", 32'(diff), 32'd0);
        chk("busy_start_first_bout", 32'(bout), 32'd0);
        @(negedge clk);
        chk("busy_start_idle_gap", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_second_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < WIDTH + 4) begin
            @(negedge clk);
            lat++;
        end
        chk("second_latency", 32'(lat), 32'(WIDTH));
        chk("second_diff", 32'(diff), 32'hF);
        chk("second_bout", 32'(bout), 32'd0);
        @(negedge clk);

        // Reset in the middle of an operation (Diff currently 1111)
        start  = 1'b1;
        a_in   = 4'b0101;
        b_in   = 4'b1010;
        bin_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (WIDTH + 3) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        run_op(4'b0111, 4'b0011, 1'b0, got_d, got_bo, got_ov, lat);
        chk("post_rst_latency", 32'(lat), 32'(WIDTH));
        chk("post_rst_diff", 32'(got_d), 32'b0100);
        chk("post_rst_bout", 32'(got_bo), 32'd0);

        // Randomized operands against the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] ra, rb;
            logic       rbin;
            ra   = 4'($urandom_range(0, 15));
            rb   = 4'($urandom_range(0, 15));
            rbin = 1'($urandom_range(0, 1));
            model(ra, rb, rbin, exp_d, exp_bo, exp_ov);
            run_op(ra, rb, rbin, got_d, got_bo, got_ov, lat);
            chk("rnd_latency", 32'(lat), 32'(WIDTH));
            chk("rnd_diff", 32'(got_d), 32'(exp_d));
            chk("rnd_bout", 32'(got_bo), 32'(exp_bo));
`ifdef SERIAL_SUB_OVF_EN
            chk("rnd_ovf", 32'(got_ov), 32'(exp_ov));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
